pong_game_ctrl: RTL



---
 rtl/pong_game_ctrl.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// ----------------------------------------------------------------------------
// pong_game_ctrl
// Game sequencer for the pong datapath. Drives the ball counters (reset and
// step enable), issues direction-flip strobes for wall and paddle bounces,
// detects misses, keeps both scores and runs the
// IDLE / SERVE / PLAY / SCORED / GAMEOVER sequence.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high
//   tick      one-cycle ball-step strobe (>= 4 cycles apart)
//   start     debounced start level (rising edge used)
//   xCoord    ball x from ball controller
//   yCoord    ball y from ball controller
//   padLY     top row of left paddle
//   padRY     top row of right paddle
//   ballEn    ball counter step enable
//   ballRst   holds ball counters at (0,0)
//   hCol      one-cycle x-direction flip pulse
//   vCol      one-cycle y-direction flip pulse
//   scoreL    left player score
//   scoreR    right player score
//   gameOver  high in GAMEOVER
//   winner    0 = left won, 1 = right won (valid with gameOver)
// ----------------------------------------------------------------------------
module pong_game_ctrl #(
   parameter int X_MAX       = 639,
   parameter int Y_MAX       = 479,
   parameter int LEFT_X      = 16,
   parameter int RIGHT_X     = 623,
   parameter int PADDLE_H    = 64,
   parameter int WIN_SCORE   = 7,
   parameter int SERVE_TICKS = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       start,
   input  logic [9:0] xCoord,
   input  logic [8:0] yCoord,
   input  logic [8:0] padLY,
   input  logic [8:0] padRY,
   output logic       ballEn,
   output logic       ballRst,
   output logic       hCol,
   output logic       vCol,
   output logic [3:0] scoreL,
   output logic [3:0] scoreR,
   output logic       gameOver,
   output logic       winner
);

   localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SERVE,
      S_PLAY,
      S_SCORED,
      S_GAMEOVER
   } state_t;

   state_t             r_state;
   state_t             w_next;

   logic               r_startD;
   logic               r_chk;
   logic               r_hDir;
   logic               r_vDir;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ballEn;
   logic               r_ballRst;
   logic               r_hCol;
   logic               r_vCol;
   logic [3:0]         r_scoreL;
   logic [3:0]         r_scoreR;
   logic               r_gameOver;
   logic               r_winner;

   logic               w_startRise;
   logic               w_missL;
   logic               w_missR;
   logic               w_hitL;
   logic               w_hitR;
   logic               w_wall;
   logic [9:0]         w_y10;
   logic [9:0]         w_padLBot;
   logic [9:0]         w_padRBot;
   logic               w_serveEntry;

   logic               w_chk_n;
   logic [CNT_W-1:0]   w_cnt_n;
   logic               w_ballEn_n;
   logic               w_ballRst_n;
   logic               w_hCol_n;
   logic               w_vCol_n;
   logic [3:0]         w_scoreL_n;
   logic [3:0]         w_scoreR_n;
   logic               w_gameOver_n;
   logic               w_winner_n;

   assign w_startRise = start & ~r_startD;

   // Paddle span is evaluated at 10 bits so a paddle near the bottom cannot wrap.
   assign w_y10     = {1'b0, yCoord};
   assign w_padLBot = {1'b0, padLY} + 10'(PADDLE_H - 1);
   assign w_padRBot = {1'b0, padRY} + 10'(PADDLE_H - 1);

   assign w_missL = (xCoord == 10'd0) && r_hDir;
   assign w_missR = (xCoord == 10'(X_MAX)) && !r_hDir;
   assign w_hitL  = (xCoord == 10'(LEFT_X)) && r_hDir &&
                    (w_y10 >= {1'b0, padLY}) && (w_y10 <= w_padLBot);
   assign w_hitR  = (xCoord == 10'(RIGHT_X)) && !r_hDir &&
                    (w_y10 >= {1'b0, padRY}) && (w_y10 <= w_padRBot);
   assign w_wall  = ((yCoord == 9'd0) && r_vDir) ||
                    ((yCoord == 9'(Y_MAX)) && !r_vDir);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_startRise) w_next = S_SERVE;
         end
         S_SERVE: begin
            if (tick && (r_cnt == CNT_W'(SERVE_TICKS - 1))) w_next = S_PLAY;
         end
         S_PLAY: begin
            if (r_chk && (w_missL || w_missR)) w_next = S_SCORED;
         end
         S_SCORED: begin
            if ((r_scoreL == 4'(WIN_SCORE)) || (r_scoreR == 4'(WIN_SCORE)))
               w_next = S_GAMEOVER;
            else
               w_next = S_SERVE;
         end
         S_GAMEOVER: begin
            if (w_startRise) w_next = S_SERVE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_serveEntry = (w_next == S_SERVE) && (r_state != S_SERVE);

   // Output / datapath next-value logic; everything is registered below.
   always_comb begin
      w_chk_n      = 1'b0;
      w_cnt_n      = r_cnt;
      w_ballEn_n   = 1'b0;
      w_ballRst_n  = (w_next != S_PLAY);
      w_hCol_n     = 1'b0;
      w_vCol_n     = 1'b0;
      w_scoreL_n   = r_scoreL;
      w_scoreR_n   = r_scoreR;
      w_gameOver_n = (w_next == S_GAMEOVER);
      w_winner_n   = r_winner;
      case (r_state)
         S_IDLE, S_GAMEOVER: begin
            if (w_startRise) begin
               w_scoreL_n = 4'd0;
               w_scoreR_n = 4'd0;
               w_winner_n = 1'b0;
            end
         end
         S_SERVE: begin
            if (tick) w_cnt_n = r_cnt + CNT_W'(1);
         end
         S_PLAY: begin
            w_ballEn_n = tick;
            // The check runs one cycle after ballEn, once the counters moved.
            w_chk_n    = r_ballEn;
            if (r_chk) begin
               if (w_missL) begin
                  w_scoreR_n = r_scoreR + 4'd1;
               end else if (w_missR) begin
                  w_scoreL_n = r_scoreL + 4'd1;
               end else begin
                  w_hCol_n = w_hitL || w_hitR;
                  w_vCol_n = w_wall;
               end
            end
         end
         S_SCORED: begin
            if (w_next == S_GAMEOVER) w_winner_n = (r_scoreR == 4'(WIN_SCORE));
         end
         default: ;
      endcase
      // Align the ball controller to +x,+y while it is held at (0,0).
      if (w_serveEntry) begin
         w_cnt_n  = '0;
         w_hCol_n = r_hDir;
         w_vCol_n = r_vDir;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_startD   <= 1'b0;
         r_chk      <= 1'b0;
         r_hDir     <= 1'b0;
         r_vDir     <= 1'b0;
         r_cnt      <= '0;
         r_ballEn   <= 1'b0;
         r_ballRst  <= 1'b1;
         r_hCol     <= 1'b0;
         r_vCol     <= 1'b0;
         r_scoreL   <= 4'd0;
         r_scoreR   <= 4'd0;
         r_gameOver <= 1'b0;
         r_winner   <= 1'b0;
      end else begin
         r_startD   <= start;
         r_chk      <= w_chk_n;
         // Mirrors track the ball controller's direction flags.
         r_hDir     <= r_hDir ^ w_hCol_n;
         r_vDir     <= r_vDir ^ w_vCol_n;
         r_cnt      <= w_cnt_n;
         r_ballEn   <= w_ballEn_n;
         r_ballRst  <= w_ballRst_n;
         r_hCol     <= w_hCol_n;
         r_vCol     <= w_vCol_n;
         r_scoreL   <= w_scoreL_n;
         r_scoreR   <= w_scoreR_n;
         r_gameOver <= w_gameOver_n;
         r_winner   <= w_winner_n;
      end
   end

   assign ballEn   = r_ballEn;
   assign ballRst  = r_ballRst;
   assign hCol     = r_hCol;
   assign vCol     = r_vCol;
   assign scoreL   = r_scoreL;
   assign scoreR   = r_scoreR;
   assign gameOver = r_gameOver;
   assign winner   = r_winner;

endmodule
